mult_hilo_sequencer: RTL and testbench
======================================

Name: mult_hilo_sequencer

Overview:
Multi-cycle multiply controller for the pipelined MIPS core. It owns the HI/LO register pair and sequences an iterative shift-add multiplier over several cycles. While a multiply is in flight it drives a stall to the pipeline registers when the EX-stage instruction depends on HI/LO or is another multiply. It sits in EX, beside the ALU, and feeds the ALU/HI/LO result select mux.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each.
BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4. ITER = WIDTH/BITS_PER_CYCLE.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  EX stage holds a valid mult/multu.
is_signed  in  1  1 = mult (two's complement), 0 = multu; sampled with start.
op_a  in  WIDTH  multiplicand (forwarded rs value).
op_b  in  WIDTH  multiplier (forwarded rt value).
rd_hi  in  1  EX stage holds mfhi.
rd_lo  in  1  EX stage holds mflo.
cancel  in  1  flush; aborts an in-flight multiply.
stall  out  1  hold IF/ID and ID/EX, and insert a bubble into EX/MEM.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse; HI/LO were just updated.
hi_out  out  WIDTH  HI register.
lo_out  out  WIDTH  LO register.

Behaviour:
- Reset: the Already-decided rule holds: one clock; reset asynchronous, active-high. Reset forces state IDLE, HI=0, LO=0, accumulator and counter 0, busy=0, done=0, stall=0. Reset mid-RUN discards the operation.
- States: IDLE, RUN, DONE.
- IDLE, start=1, cancel=0:
  - Latch |op_a| and |op_b|. Magnitudes are taken only when is_signed=1 and the operand MSB is 1. 0x80000000 maps to magnitude 0x80000000 as unsigned.
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Clear the 2*WIDTH accumulator, set count=0, go to RUN.
  - stall=0 in this cycle; the mult itself leaves EX normally.
- RUN:
  - Each cycle, add (multiplicand << shift) times the low BITS_PER_CYCLE multiplier bits into the accumulator, then shift the multiplier right and increment count.
  - On the edge where count reaches ITER-1:
    - {HI,LO} <= neg ? -acc_final : acc_final, computed modulo 2^(2*WIDTH).
    - Go to DONE.
  - Latency: start sampled at edge E0; HI/LO hold the new value after edge E0+ITER. With the defaults this is 32 cycles.
  - stall = start | rd_hi | rd_lo, combinational. The stalled instruction stays in EX with its inputs held.
  - cancel=1 in RUN: go to IDLE at the next edge. HI/LO are unchanged and no done pulse is issued. cancel has priority over completion in the same cycle.
- DONE (exactly one cycle):
  - done=1, busy=0, stall=0.
  - A held mfhi/mflo reads the new HI/LO in this cycle.
  - start in DONE is accepted exactly as in IDLE (back-to-back multiplies). Otherwise go to IDLE.
- cancel and start together in IDLE or DONE: cancel wins, start is ignored, and the state stays or becomes IDLE.
- hi_out and lo_out are direct register outputs. They never glitch to partial products; the accumulator is internal.
- rd_hi/rd_lo in IDLE or DONE: no stall.

Optional Feature:
Macro HILO_WRITE_EN.
- Defined: adds ports wr_hi (in 1), wr_lo (in 1) and wr_data (in WIDTH) for mthi/mtlo.
  - In IDLE or DONE, wr_hi/wr_lo write wr_data into HI/LO at the edge.
  - In RUN, wr_hi or wr_lo also raises stall, and the write is applied once stall drops. This preserves program order versus the multiply result.
  - wr_* with start in the same cycle: the write is applied and the multiply is also captured; the multiply result overwrites later.
- Undefined: the ports are absent and HI/LO are written only by multiply completion.

Test Plan:
1. Reset, then start multu 7×6 (0x7, 0x6) → busy high for 32 cycles; done pulses on cycle 33; HI=0x00000000, LO=0x0000002A.
2. mult 0xFFFFFFFD×0x00000005 (−3×5) → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also run mult 0x80000000×0x80000000 → HI=0x40000000, LO=0x00000000.
3. multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Repeat with BITS_PER_CYCLE=4 → identical result, busy 8 cycles.
4. Assert rd_lo 3 cycles after start and hold it → stall=1 for the remaining 29 RUN cycles. stall=0 in the DONE cycle, with lo_out already showing the new product.
5. Start 0x3×0x4 after a prior result HI=0x1, LO=0x2; assert cancel on RUN cycle 10 → IDLE next cycle, HI=0x1 and LO=0x2 kept, no done. Repeat with rst asserted mid-RUN → HI=LO=0 immediately.
6. Second start during RUN → stall until DONE. The second start is accepted in the DONE cycle and completes 32 cycles later with its own product. With HILO_WRITE_EN defined, wr_hi=1 and wr_data=0xABCD in IDLE → HI=0xABCD next cycle.

Source files
------------

// File: rtl/mult_hilo_sequencer.sv
// Multi-cycle shift-add multiply sequencer owning the HI/LO pair, with pipeline stall generation.
// Optional mthi/mtlo write ports are enabled by defining HILO_WRITE_EN.
module mult_hilo_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             cancel,
`ifdef HILO_WRITE_EN
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [AW-1:0]    acc_r;
    logic [AW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CNT_W-1:0] count_r;
    logic             neg_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             accept_s;
    logic             last_s;
    logic             dep_s;
    logic [AW-1:0]    acc_sum_s;
    logic [AW-1:0]    product_s;

    // Unsigned magnitude; the most negative value maps onto itself, which is correct as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [AW-1:0] partial(input logic [AW-1:0] mcand,
                                              input logic [BITS_PER_CYCLE-1:0] bits);
        logic [AW-1:0] sum;
        sum = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            sum = sum + (bits[j] ? (mcand << j) : '0);
        end
        return sum;
    endfunction

    // Acceptance, completion and datapath arithmetic decode.
    always_comb begin
        accept_s  = start & ~cancel & (state_r != S_RUN);
        last_s    = (state_r == S_RUN) && (count_r == LAST_CNT);
        acc_sum_s = acc_r + partial(mcand_r, mplier_r[BITS_PER_CYCLE-1:0]);
        product_s = neg_r ? -acc_sum_s : acc_sum_s;
`ifdef HILO_WRITE_EN
        dep_s     = start | rd_hi | rd_lo | wr_hi | wr_lo;
`else
        dep_s     = start | rd_hi | rd_lo;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cancel outranks both completion and a new start.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (accept_s) state_nxt_s = S_RUN;
                else          state_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (cancel)      state_nxt_s = S_IDLE;
                else if (last_s) state_nxt_s = S_DONE;
                else             state_nxt_s = S_RUN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode; only RUN can hold the pipeline.
    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_r)
            S_IDLE: begin
                stall = 1'b0;
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = dep_s;
            end
            S_DONE: begin
                done  = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Operand capture and one shift-add step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            count_r  <= '0;
            neg_r    <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= '0;
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(op_a, is_signed)};
            mplier_r <= magnitude(op_b, is_signed);
            count_r  <= '0;
            neg_r    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (state_r == S_RUN) begin
            acc_r    <= acc_sum_s;
            mcand_r  <= mcand_r << BITS_PER_CYCLE;
            mplier_r <= mplier_r >> BITS_PER_CYCLE;
            count_r  <= count_r + CNT_W'(1);
        end
    end

    // HI/LO only change on a completed product (or, optionally, a direct write outside RUN).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (last_s && !cancel) begin
            hi_r <= product_s[AW-1:WIDTH];
            lo_r <= product_s[WIDTH-1:0];
        end
`ifdef HILO_WRITE_EN
        else if (state_r != S_RUN) begin
            if (wr_hi) hi_r <= wr_data;
            if (wr_lo) lo_r <= wr_data;
        end
`endif
    end

    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed self-checking bench for mult_hilo_sequencer (BITS_PER_CYCLE 1 and 4 instances).
module tb_mult_hilo_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, start4, is_signed, rd_hi, rd_lo, cancel;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done, stall4, busy4, done4;
    logic [31:0] hi_out, lo_out, hi4, lo4;
`ifdef HILO_WRITE_EN
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'd0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int cnt;

    always #5 clk = ~clk;

    mult_hilo_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .rd_hi(rd_hi), .rd_lo(rd_lo), .cancel(cancel),
`ifdef HILO_WRITE_EN
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
`endif
        .stall(stall), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    mult_hilo_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .rd_hi(rd_hi), .rd_lo(rd_lo), .cancel(cancel),
`ifdef HILO_WRITE_EN
        .wr_hi(zero1), .wr_lo(zero1), .wr_data(zero32),
`endif
        .stall(stall4), .busy(busy4), .done(done4), .hi_out(hi4), .lo_out(lo4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a multiply for one cycle; returns 1ns after the accepting edge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        @(negedge clk);
        check("start_cycle_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_mult(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start_op(sgn, a, b);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd32);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi_out), 64'(ehi));
        check({tag, "_lo"}, 64'(lo_out), 64'(elo));
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; is_signed = 1'b0; rd_hi = 1'b0;
        rd_lo = 1'b0; cancel = 1'b0; op_a = 32'd0; op_b = 32'd0;
`ifdef HILO_WRITE_EN
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_stall4", 64'(stall4), 64'd0);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_hi = 1'b1;
        @(negedge clk);
        check("idle_rd_hi_no_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rd_hi = 1'b0;

        do_mult("multu_7x6", 1'b0, 32'h7, 32'h6, 32'h0, 32'h2A);
        do_mult("mult_m3x5", 1'b1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_mult("mult_min_sq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        do_mult("multu_max_sq", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);

        // Same product on the 4-bits-per-cycle instance.
        @(posedge clk); #1;
        start4 = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy4 === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("bpc4_busy_cycles", 64'(cyc), 64'd8);
        check("bpc4_done", 64'(done4), 64'd1);
        check("bpc4_hi", 64'(hi4), 64'hFFFFFFFE);
        check("bpc4_lo", 64'(lo4), 64'h1);

        // mflo held from the fourth RUN cycle onward.
        start_op(1'b0, 32'h1234, 32'h10);
        repeat (3) @(posedge clk);
        #1 rd_lo = 1'b1;
        cnt = 0; cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (stall === 1'b1) cnt++;
            @(negedge clk);
        end
        check("rdlo_stall_cycles", 64'(cnt), 64'd29);
        check("rdlo_done_stall", 64'(stall), 64'd0);
        check("rdlo_done_lo", 64'(lo_out), 64'h12340);
        @(posedge clk); #1;
        rd_lo = 1'b0;

        // Cancel on RUN cycle 10 keeps the prior HI/LO.
        do_mult("prior", 1'b0, 32'h2, 32'h80000001, 32'h1, 32'h2);
        start_op(1'b0, 32'h3, 32'h4);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        check("cancel_still_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle", 64'(busy), 64'd0);
        check("cancel_hi_kept", 64'(hi_out), 64'h1);
        check("cancel_lo_kept", 64'(lo_out), 64'h2);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cnt++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(cnt), 64'd0);

        // cancel with start in IDLE ignores the start.
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cancel_start_idle", 64'(busy), 64'd0);

        // Back-to-back: a second start during RUN stalls, then is taken in DONE.
        start_op(1'b0, 32'h7, 32'h9);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op_a = 32'h5; op_b = 32'hB;
        cnt = 0; cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (stall !== 1'b1) cnt++;
            @(negedge clk);
        end
        check("b2b_stall_held", 64'(cnt), 64'd0);
        check("b2b_done_stall", 64'(stall), 64'd0);
        check("b2b_first_lo", 64'(lo_out), 64'h3F);
        check("b2b_first_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_second_cycles", 64'(cyc), 64'd32);
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_second_hi", 64'(hi_out), 64'h0);
        check("b2b_second_lo", 64'(lo_out), 64'h37);

`ifdef HILO_WRITE_EN
        @(posedge clk); #1;
        wr_hi = 1'b1; wr_data = 32'hABCD;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        @(negedge clk);
        check("mthi_idle", 64'(hi_out), 64'hABCD);
`endif

        // Reset mid-RUN clears HI/LO without waiting for a clock edge.
        start_op(1'b0, 32'h3, 32'h4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_hi", 64'(hi_out), 64'h0);
        check("rst_mid_lo", 64'(lo_out), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
